// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: shared bus widths, LED panel address and arbiter state encoding
package periph_bus_pkg;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;
    localparam logic [ADDR_W-1:0] LED_PANEL_ADDR = 19'h5c00;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
endpackage

// File: rtl/periph_bus_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin selector; on a tie the master other than last wins
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);
    always_comb begin
        valid  = |req;
        winner = &req ? ~last : req[1];
    end
endmodule

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: shares the peripheral bus between two masters, one transaction at a time
module periph_bus_arbiter #(
    parameter int ADDR_W       = periph_bus_pkg::ADDR_W,
    parameter int DATA_W       = periph_bus_pkg::DATA_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_grant,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_grant,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);
    import periph_bus_pkg::*;

    if (READ_LATENCY < 1 || READ_LATENCY > 7) begin : g_bad_latency
        $error("READ_LATENCY must be within 1..7");
    end

    localparam logic [2:0] CNT_LOAD = 3'(READ_LATENCY - 1);

    arb_state_t        state, next_state;
    logic              valid, winner, owner, last_grant, lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [2:0]        cnt;

    rr_pick2 u_pick (
        .req    ({m1_req, m0_req}),
        .last   (last_grant),
        .valid  (valid),
        .winner (winner)
    );

    always_ff @(posedge clock)
        state <= !reset ? IDLE : next_state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  next_state = valid ? ISSUE : IDLE;
            ISSUE: next_state = WAIT;
            WAIT:  next_state = cnt == 3'd0 ? DONE : WAIT;
            DONE:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            cnt        <= '0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            if (state == IDLE && valid) begin
                owner     <= winner;
                lat_addr  <= winner ? m1_addr : m0_addr;
                lat_we    <= winner ? m1_we : m0_we;
                lat_wdata <= winner ? m1_wdata : m0_wdata;
            end
            if (state == ISSUE || state == WAIT)
                cnt <= state == ISSUE ? CNT_LOAD : cnt - 3'd1;
            // Writes capture too; the value is meaningless but keeps the path uniform
            if (state == WAIT && cnt == 3'd0) begin
                if (owner)
                    m1_rdata <= bus_rdata;
                else
                    m0_rdata <= bus_rdata;
            end
            if (state == DONE)
                last_grant <= owner;
        end
    end

    always_comb begin
        m0_grant  = state != IDLE && !owner;
        m1_grant  = state != IDLE && owner;
        m0_done   = state == DONE && !owner;
        m1_done   = state == DONE && owner;
        bus_we    = state == ISSUE && lat_we;
        bus_addr  = lat_addr;
        bus_wdata = lat_wdata;
    end
endmodule
